// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter: pipeline writeback versus a 2-entry aux FIFO.
// Optional scan display compiled in with macro WB_PORT_ARBITER_SCAN_EN.
module wb_port_arbiter #(
    parameter int CORE            = 0,
    parameter int DATA_WIDTH      = 32,
    parameter int STARVE_LIMIT    = 4,
    parameter int SCAN_CYCLES_MIN = 0,
    parameter int SCAN_CYCLES_MAX = 1000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pipe_write,
    input  logic [4:0]            pipe_write_reg,
    input  logic [DATA_WIDTH-1:0] pipe_write_data,
    input  logic                  aux_valid,
    input  logic [4:0]            aux_reg,
    input  logic [DATA_WIDTH-1:0] aux_data,
    output logic                  aux_ready,
    output logic                  stall_pipe,
    output logic                  write,
    output logic [4:0]            write_reg,
    output logic [DATA_WIDTH-1:0] write_data,
    input  logic                  scan
);

    localparam logic [7:0] LP_LIMIT = 8'(STARVE_LIMIT);

    typedef enum logic {
        ST_NORMAL  = 1'b0,
        ST_STARVED = 1'b1
    } state_t;

    state_t                r_state;
    logic                  r_stall;
    logic [4:0]            r_fifo_reg  [2];
    logic [DATA_WIDTH-1:0] r_fifo_data [2];
    logic                  r_rd_ptr;
    logic                  r_wr_ptr;
    logic [1:0]            r_count;
    logic [7:0]            r_wait;
    logic                  r_write;
    logic [4:0]            r_write_reg;
    logic [DATA_WIDTH-1:0] r_write_data;
    logic [31:0]           r_cycle;

    logic                  w_push;
    logic                  w_not_empty;
    logic                  w_pipe_sel;
    logic                  w_pop;
    logic                  w_sel_valid;
    logic [4:0]            w_sel_reg;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_do_write;
    logic [7:0]            w_wait_next;

    // Ready depends only on registered occupancy, so it never loops through aux_valid.
    assign aux_ready   = (r_count < 2'd2);
    assign stall_pipe  = r_stall;
    assign write       = r_write;
    assign write_reg   = r_write_reg;
    assign write_data  = r_write_data;

    assign w_push      = aux_valid & aux_ready;
    assign w_not_empty = (r_count != 2'd0);

    // Pipe wins only in NORMAL; the head is taken from registered count, so an
    // entry pushed this cycle cannot be popped until the next one.
    assign w_pipe_sel  = (r_state == ST_NORMAL) & pipe_write;
    assign w_pop       = w_not_empty & ~w_pipe_sel;
    assign w_sel_valid = w_pipe_sel | w_pop;
    assign w_sel_reg   = w_pipe_sel ? pipe_write_reg  : r_fifo_reg[r_rd_ptr];
    assign w_sel_data  = w_pipe_sel ? pipe_write_data : r_fifo_data[r_rd_ptr];
    assign w_do_write  = w_sel_valid & (w_sel_reg != 5'd0);

    // Wait count tracks how long the current head has been passed over.
    assign w_wait_next = (!w_not_empty || w_pop) ? 8'd0 : (r_wait + 8'd1);

    // Arbitration FSM: force one aux pop once the head has waited long enough.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_NORMAL;
            r_stall <= 1'b0;
            r_wait  <= 8'd0;
        end else begin
            r_wait <= w_wait_next;
            unique case (r_state)
                ST_NORMAL: begin
                    if (w_wait_next >= LP_LIMIT) begin
                        r_state <= ST_STARVED;
                        r_stall <= 1'b1;
                    end else begin
                        r_state <= ST_NORMAL;
                        r_stall <= 1'b0;
                    end
                end
                ST_STARVED: begin
                    r_state <= ST_NORMAL;
                    r_stall <= 1'b0;
                end
                default: begin
                    r_state <= ST_NORMAL;
                    r_stall <= 1'b0;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; push and pop together leave count unchanged.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents are don't-care once pointers are reset.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_reg[r_wr_ptr]  <= aux_reg;
            r_fifo_data[r_wr_ptr] <= aux_data;
        end
    end

    // Registered write port; writes to x0 are dropped and idle outputs are zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_write      <= 1'b0;
            r_write_reg  <= 5'd0;
            r_write_data <= '0;
        end else if (w_do_write) begin
            r_write      <= 1'b1;
            r_write_reg  <= w_sel_reg;
            r_write_data <= w_sel_data;
        end else begin
            r_write      <= 1'b0;
            r_write_reg  <= 5'd0;
            r_write_data <= '0;
        end
    end

    // Free-running cycle counter for debug display.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cycle <= 32'd0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

`ifdef WB_PORT_ARBITER_SCAN_EN
    // Per-cycle trace of the arbiter inside the configured cycle window.
    always_ff @(posedge clock) begin
        if (scan &&
            (r_cycle >= 32'(SCAN_CYCLES_MIN)) &&
            (r_cycle <= 32'(SCAN_CYCLES_MAX))) begin
            $display("core %0d cycle %0d state %0d count %0d write %0b reg %0d data %h",
                     CORE, r_cycle, r_state, r_count,
                     r_write, r_write_reg, r_write_data);
        end
    end
`else
    logic w_unused_scan;
    assign w_unused_scan = ^{scan, r_cycle, 32'(CORE),
                             32'(SCAN_CYCLES_MIN), 32'(SCAN_CYCLES_MAX)};
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: directed vectors push expected
// writes (cycle, reg, data); a negedge monitor pops and compares.
module tb_wb_port_arbiter;

    logic        clk;
    logic        reset;
    logic        pipe_write;
    logic [4:0]  pipe_write_reg;
    logic [31:0] pipe_write_data;
    logic        aux_valid;
    logic [4:0]  aux_reg;
    logic [31:0] aux_data;
    logic        aux_ready;
    logic        stall_pipe;
    logic        write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        scan;

    typedef struct {
        int          cyc;
        logic [4:0]  rg;
        logic [31:0] dat;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    wb_port_arbiter #(
        .CORE(0), .DATA_WIDTH(32), .STARVE_LIMIT(4),
        .SCAN_CYCLES_MIN(0), .SCAN_CYCLES_MAX(1000)
    ) dut (
        .clock(clk), .reset(reset),
        .pipe_write(pipe_write), .pipe_write_reg(pipe_write_reg),
        .pipe_write_data(pipe_write_data),
        .aux_valid(aux_valid), .aux_reg(aux_reg), .aux_data(aux_data),
        .aux_ready(aux_ready), .stall_pipe(stall_pipe),
        .write(write), .write_reg(write_reg), .write_data(write_data),
        .scan(scan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every write must match the head of the scoreboard exactly.
    always @(negedge clk) begin
        checks++;
        if (write === 1'b1) begin
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write cyc %0d got reg %0d data %h, none expected",
                         cyc, write_reg, write_data);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (e.cyc != cyc || e.rg !== write_reg || e.dat !== write_data) begin
                    errors++;
                    $display("FAIL write_match got cyc %0d reg %0d data %h, want cyc %0d reg %0d data %h",
                             cyc, write_reg, write_data, e.cyc, e.rg, e.dat);
                end
            end
        end else if (write !== 1'b0 || write_reg !== 5'd0 || write_data !== 32'd0) begin
            errors++;
            $display("FAIL idle_zero cyc %0d got write %b reg %0d data %h, want 0 0 0",
                     cyc, write, write_reg, write_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expw(input int at, input logic [4:0] rg, input logic [31:0] d);
        exp_t e;
        e.cyc = at;
        e.rg  = rg;
        e.dat = d;
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc %0d got %h want %h", nm, cyc, got, want);
        end
    endtask

    task automatic set_pipe(input logic v, input logic [4:0] r, input logic [31:0] d);
        pipe_write      = v;
        pipe_write_reg  = r;
        pipe_write_data = d;
    endtask

    task automatic set_aux(input logic v, input logic [4:0] r, input logic [31:0] d);
        aux_valid = v;
        aux_reg   = r;
        aux_data  = d;
    endtask

    initial begin
        int k;
        reset = 1'b1;
        scan  = 1'b0;
        set_pipe(0, 0, 0);
        set_aux(0, 0, 0);
        step();
        step();
        @(negedge clk);
        chk("rst_write", 32'(write), 0);
        chk("rst_stall", 32'(stall_pipe), 0);
        chk("rst_ready", 32'(aux_ready), 1);
        chk("rst_reg", 32'(write_reg), 0);
        step();
        reset = 1'b0;
        step();

        // Pipe write appears one cycle after acceptance.
        k = cyc;
        set_pipe(1, 5, 32'hA5A5A5A5);
        expw(k + 1, 5, 32'hA5A5A5A5);
        step();
        set_pipe(0, 0, 0);
        repeat (3) step();

        // Two aux entries, pipe idle: in order, two-cycle latency each.
        k = cyc;
        set_aux(1, 7, 32'h11);
        expw(k + 2, 7, 32'h11);
        step();
        set_aux(1, 8, 32'h22);
        expw(k + 3, 8, 32'h22);
        step();
        set_aux(0, 0, 0);
        repeat (4) step();

        // Starvation: pipe busy every cycle, one aux entry forces a stall.
        k = cyc;
        for (int i = 0; i < 8; i++) begin
            set_pipe(1, 5'(10 + i), 32'h1000 + i);
            if (i == 0) set_aux(1, 9, 32'h99);
            else set_aux(0, 0, 0);
            if (i == 5) expw(k + 6, 9, 32'h99);
            else expw(k + i + 1, 5'(10 + i), 32'h1000 + i);
            @(negedge clk);
            chk($sformatf("stall_%0d", i), 32'(stall_pipe), (i == 5) ? 1 : 0);
            step();
        end
        set_pipe(0, 0, 0);
        repeat (3) step();

        // Aux write to x0 is popped but never written.
        set_aux(1, 0, 32'hFF);
        step();
        set_aux(0, 0, 0);
        step();
        step();
        @(negedge clk);
        chk("x0_ready", 32'(aux_ready), 1);
        k = cyc;
        set_aux(1, 3, 32'h33);
        expw(k + 2, 3, 32'h33);
        step();
        set_aux(0, 0, 0);
        repeat (4) step();

        // FIFO full with aux_valid held: no push until a pop.
        k = cyc;
        set_pipe(1, 11, 32'hB0);
        set_aux(1, 12, 32'hC12);
        expw(k + 1, 11, 32'hB0);
        step();
        set_pipe(1, 11, 32'hB1);
        set_aux(1, 13, 32'hC13);
        expw(k + 2, 11, 32'hB1);
        step();
        set_pipe(1, 11, 32'hB2);
        set_aux(1, 14, 32'hC14);
        expw(k + 3, 11, 32'hB2);
        @(negedge clk);
        chk("full_ready_a", 32'(aux_ready), 0);
        step();
        set_pipe(1, 11, 32'hB3);
        expw(k + 4, 11, 32'hB3);
        @(negedge clk);
        chk("full_ready_b", 32'(aux_ready), 0);
        step();
        set_pipe(0, 0, 0);
        expw(k + 5, 12, 32'hC12);
        @(negedge clk);
        chk("full_ready_c", 32'(aux_ready), 0);
        step();
        expw(k + 6, 13, 32'hC13);
        @(negedge clk);
        chk("pop_ready", 32'(aux_ready), 1);
        step();
        set_aux(0, 0, 0);
        expw(k + 7, 14, 32'hC14);
        repeat (4) step();

        // Reset with two queued entries flushes them.
        k = cyc;
        set_pipe(1, 20, 32'hD0);
        set_aux(1, 21, 32'hE1);
        expw(k + 1, 20, 32'hD0);
        step();
        set_pipe(1, 20, 32'hD1);
        set_aux(1, 22, 32'hE2);
        expw(k + 2, 20, 32'hD1);
        step();
        set_pipe(0, 0, 0);
        set_aux(0, 0, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("flush_write", 32'(write), 0);
        chk("flush_ready", 32'(aux_ready), 1);
        chk("flush_stall", 32'(stall_pipe), 0);
        repeat (8) step();

        chk("sb_empty", 32'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter CORE, 0, core index used in scan output.
REQ-002 SHALL have parameter DATA_WIDTH, 32, register data width.
REQ-003 SHALL have parameter STARVE_LIMIT, 4, consecutive cycles an aux entry may wait before forced service; legal range 1..255.
REQ-004 SHALL have parameter SCAN_CYCLES_MIN, 0, first cycle of scan output.
REQ-005 SHALL have parameter SCAN_CYCLES_MAX, 1000, last cycle of scan output.
REQ-006 SHALL have port clock  input  1  sole clock; all state updates on posedge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port pipe_write  input  1  pipeline writeback request.
REQ-009 SHALL have port pipe_write_reg  input  5  pipeline destination register.
REQ-010 SHALL have port pipe_write_data  input  DATA_WIDTH  pipeline result.
REQ-011 SHALL have port aux_valid  input  1  aux unit (CSR/long-latency) result offered.
REQ-012 SHALL have port aux_reg  input  5  aux destination register.
REQ-013 SHALL have port aux_data  input  DATA_WIDTH  aux result.
REQ-014 SHALL have port aux_ready  output  1  aux FIFO can accept an entry this cycle.
REQ-015 SHALL have port stall_pipe  output  1  pipeline must hold; pipe_write is ignored while high.
REQ-016 SHALL have port write  output  1  register file write enable.
REQ-017 SHALL have port write_reg  output  5  register file write address.
REQ-018 SHALL have port write_data  output  DATA_WIDTH  register file write data.
REQ-019 SHALL have port scan  input  1  enables debug display.

Function
REQ-020 SHALL hold aux entries in a 2-entry FIFO; aux transfer occurs when aux_valid & aux_ready at posedge.
REQ-021 SHALL drive aux_ready = (FIFO count < 2), combinational from registered count only.
REQ-022 SHALL register write/write_reg/write_data: a selected request appears on outputs exactly 1 cycle after its acceptance.
REQ-023 SHALL, in state NORMAL, select pipe when pipe_write=1, else FIFO head if non-empty, else drive write=0.
REQ-024 SHALL never write the same aux entry in the cycle it is pushed (minimum aux latency: push cycle + 1 to pop, + 1 to output).
REQ-025 SHALL keep an 8-bit wait counter: increments each cycle the FIFO is non-empty and head not popped; clears on pop or empty.
REQ-026 SHALL transition NORMAL->STARVED when wait counter reaches STARVE_LIMIT.
REQ-027 SHALL, in STARVED, assert stall_pipe, ignore pipe_write, pop FIFO head to the write port, then return to NORMAL next cycle.
REQ-028 SHALL deassert stall_pipe in NORMAL.
REQ-029 SHALL, on simultaneous pop and push with count 1 or 2, keep count unchanged with correct ordering (FIFO order preserved).
REQ-030 SHALL suppress write (write=0) for any selected request whose destination register is 0; the aux entry is still popped.
REQ-031 SHALL drive write_reg and write_data to 0 whenever write=0.

Reset
REQ-032 SHALL, on reset at posedge, set state NORMAL, FIFO count 0, wait counter 0, write=0, write_reg=0, write_data=0, stall_pipe=0; aux_ready=1 the following cycle.
REQ-033 SHALL discard all FIFO contents on reset mid-operation; no write of a flushed entry occurs after reset.
REQ-034 SHALL keep a 32-bit cycle counter reset to 0 and incremented every non-reset cycle.

Configuration
REQ-035 SHALL compile scan display under macro WB_PORT_ARBITER_SCAN_EN: with it defined, when scan=1 and SCAN_CYCLES_MIN <= cycle <= SCAN_CYCLES_MAX, print core, cycle, state, FIFO count, write, write_reg, write_data each cycle; without it, no display code exists and the scan input is unused; functional behaviour identical in both builds.

Verification
REQ-036 SHALL verify: reset, then pipe_write=1 reg=5 data=0xA5A5A5A5 -> next cycle write=1, write_reg=5, write_data=0xA5A5A5A5.
REQ-037 SHALL verify: push aux reg=7 data=0x11 and reg=8 data=0x22 with pipe idle -> writes to 7 then 8 on consecutive cycles, in order; aux_ready=0 while count=2.
REQ-038 SHALL verify: STARVE_LIMIT=4, pipe_write=1 every cycle, one aux entry reg=9 -> stall_pipe=1 for exactly one cycle after 4 wait cycles, write_reg=9 one cycle later, pipe writes resume.
REQ-039 SHALL verify: aux entry reg=0 data=0xFF with pipe idle -> write stays 0, FIFO count returns to 0.
REQ-040 SHALL verify: two aux entries queued, reset asserted one cycle -> write=0, aux_ready=1 after reset, no write to queued registers ever appears.
REQ-041 SHALL verify: FIFO count=2 with aux_valid=1 held -> no push accepted until a pop; count never exceeds 2.
